crc_serial_gen: RTL and testbench

CRC_SERIAL_GEN -- requirements
Module: crc_serial_gen

---
 rtl/crc_pkg.sv | 15 +
 rtl/crc_serial_gen_if.sv | 36 +++
 rtl/crc_lfsr_step.sv | 21 ++
 rtl/crc_serial_gen.sv | 127 ++++++++++++
 tb/tb_crc_serial_gen.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/crc_pkg.sv
// Shared constants and FSM state type for the serial CRC generator.
// Optional zero-check outputs are enabled with `define CRC_CHECK_EN.
package crc_pkg;

  localparam int unsigned DefWidth = 8;
  localparam logic [7:0]  DefPoly  = 8'h44;
  localparam logic [7:0]  DefSeed  = 8'hD8;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StShiftIn  = 2'd1,
    StShiftOut = 2'd2
  } crc_state_e;

endpackage

// File: rtl/crc_serial_gen_if.sv
// Serial message/CRC bus for crc_serial_gen; master drives the message, slave returns the CRC.
// With `define CRC_CHECK_EN the bus also carries chk_done/chk_ok from the slave.
interface crc_serial_gen_if;

  logic data;
  logic active;
  logic crc;
  logic valid;
  logic busy;

`ifdef CRC_CHECK_EN
  logic chk_done;
  logic chk_ok;

  modport master (
    output data, active,
    input  crc, valid, busy, chk_done, chk_ok
  );

  modport slave (
    input  data, active,
    output crc, valid, busy, chk_done, chk_ok
  );
`else
  modport master (
    output data, active,
    input  crc, valid, busy
  );

  modport slave (
    input  data, active,
    output crc, valid, busy
  );
`endif

endinterface

// File: rtl/crc_lfsr_step.sv
// One-bit Galois LFSR step: the feedback enters the top stage and is XORed into tapped stages.
module crc_lfsr_step
  import crc_pkg::*;
#(
  parameter int unsigned      WIDTH = DefWidth,
  parameter logic [WIDTH-1:0] POLY  = DefPoly
) (
  input  logic [WIDTH-1:0] reg_i,
  input  logic             data_i,
  output logic [WIDTH-1:0] reg_o
);

  logic fb;

  always_comb begin
    fb    = reg_i[0] ^ data_i;
    // The top tap bit is not used: the top stage always takes the raw feedback.
    reg_o = {fb, reg_i[WIDTH-1:1]} ^ ({WIDTH{fb}} & {1'b0, POLY[WIDTH-2:0]});
  end

endmodule

// File: rtl/crc_serial_gen.sv
// Serial CRC generator: absorbs message bits while active, then shifts the CRC out LSB first.
// `define CRC_CHECK_EN adds a chk_done/chk_ok pulse reporting whether the register was zero.
module crc_serial_gen
  import crc_pkg::*;
#(
  parameter int unsigned      WIDTH = DefWidth,
  parameter logic [WIDTH-1:0] POLY  = DefPoly,
  parameter logic [WIDTH-1:0] SEED  = DefSeed
) (
  input logic             CLK,
  input logic             RST,
  crc_serial_gen_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  crc_state_e       state_q, state_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic [WIDTH-1:0] step_reg;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             crc_q, crc_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             frame_end;

  crc_lfsr_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_step (
    .reg_i  (reg_q),
    .data_i (bus.data),
    .reg_o  (step_reg)
  );

  assign frame_end = (state_q == StShiftIn) && !bus.active;

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle, StShiftIn: begin
        if (bus.active) begin
          reg_d   = step_reg;
          state_d = StShiftIn;
        end else if (frame_end) begin
          state_d = StShiftOut;
          crc_d   = reg_q[0];
          valid_d = 1'b1;
          busy_d  = 1'b1;
          reg_d   = reg_q >> 1;
          cnt_d   = CntW'(1);
        end
      end
      StShiftOut: begin
        // cnt_q counts bits already presented; input is ignored throughout.
        if (cnt_q == CntW'(WIDTH)) begin
          state_d = StIdle;
          crc_d   = 1'b0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          reg_d   = SEED;
          cnt_d   = '0;
        end else begin
          crc_d = reg_q[0];
          reg_d = reg_q >> 1;
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        reg_d   = SEED;
        cnt_d   = '0;
        crc_d   = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StIdle;
      reg_q   <= SEED;
      cnt_q   <= '0;
      crc_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      cnt_q   <= cnt_d;
      crc_q   <= crc_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.crc   = crc_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;

`ifdef CRC_CHECK_EN
  logic chk_done_q;
  logic chk_ok_q;

  // chk_ok looks at the register before the first output shift; it holds until the next frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      chk_done_q <= 1'b0;
      chk_ok_q   <= 1'b0;
    end else begin
      chk_done_q <= frame_end;
      if (frame_end) begin
        chk_ok_q <= (reg_q == '0);
      end
    end
  end

  assign bus.chk_done = chk_done_q;
  assign bus.chk_ok   = chk_ok_q;
`endif

endmodule

// File: tb/tb_crc_serial_gen.sv
// Self-checking bench for crc_serial_gen: three configurations driven in lockstep,
// table vectors, hand-written corner sequences and random frames against a reference model.
module tb_crc_serial_gen;

  logic CLK;
  logic RST;

  crc_serial_gen_if ifa ();
  crc_serial_gen_if ifb ();
  crc_serial_gen_if ifc ();

  crc_serial_gen #(.WIDTH(8), .POLY(8'h44), .SEED(8'h00)) dut_a (
    .CLK (CLK), .RST (RST), .bus (ifa)
  );
  crc_serial_gen #(.WIDTH(8), .POLY(8'h44), .SEED(8'hD8)) dut_b (
    .CLK (CLK), .RST (RST), .bus (ifb)
  );
  crc_serial_gen #(.WIDTH(16), .POLY(16'h8408), .SEED(16'hFFFF)) dut_c (
    .CLK (CLK), .RST (RST), .bus (ifc)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int          len;
    logic [63:0] msg;
    logic [7:0]  exp_a;
  } vec_t;

  vec_t vecs[5];

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Message bit i is presented on the i-th active cycle; the CRC rule is applied bit by bit.
  function automatic logic [31:0] model_crc(input int unsigned w, input logic [31:0] poly,
                                            input logic [31:0] seed, input int len,
                                            input logic [63:0] msg);
    logic [31:0] r;
    logic [31:0] low_taps;
    logic        fb;
    r        = seed;
    low_taps = poly & ((32'd1 << (w - 1)) - 32'd1);
    for (int i = 0; i < len; i++) begin
      fb = r[0] ^ msg[i];
      r  = r >> 1;
      if (fb) r = r ^ low_taps ^ (32'd1 << (w - 1));
    end
    return r;
  endfunction

  task automatic drive(input logic d, input logic a);
    ifa.data = d;  ifa.active = a;
    ifb.data = d;  ifb.active = a;
    ifc.data = d;  ifc.active = a;
  endtask

  task automatic check_idle(input string tag);
    cmp({tag, "/a"}, {29'd0, ifa.valid, ifa.busy, ifa.crc}, 32'd0);
    cmp({tag, "/b"}, {29'd0, ifb.valid, ifb.busy, ifb.crc}, 32'd0);
    cmp({tag, "/c"}, {29'd0, ifc.valid, ifc.busy, ifc.crc}, 32'd0);
  endtask

  task automatic check_out(input string tag, input int i, input logic [31:0] ea,
                           input logic [31:0] eb, input logic [31:0] ec);
    logic va, vc, ca, cb, cc;
    va = (i < 8);
    vc = (i < 16);
    ca = va ? ea[i] : 1'b0;
    cb = va ? eb[i] : 1'b0;
    cc = vc ? ec[i] : 1'b0;
    cmp($sformatf("%s/a[%0d] v,b,crc", tag, i), {29'd0, ifa.valid, ifa.busy, ifa.crc},
        {29'd0, va, va, ca});
    cmp($sformatf("%s/b[%0d] v,b,crc", tag, i), {29'd0, ifb.valid, ifb.busy, ifb.crc},
        {29'd0, va, va, cb});
    cmp($sformatf("%s/c[%0d] v,b,crc", tag, i), {29'd0, ifc.valid, ifc.busy, ifc.crc},
        {29'd0, vc, vc, cc});
`ifdef CRC_CHECK_EN
    cmp($sformatf("%s/a[%0d] chk_done", tag, i), {31'd0, ifa.chk_done}, {31'd0, (i == 0)});
    if (i == 0) begin
      cmp($sformatf("%s/a chk_ok", tag), {31'd0, ifa.chk_ok}, {31'd0, (ea[7:0] == 8'd0)});
    end
`endif
  endtask

  task automatic send_bits(input int len, input logic [63:0] msg);
    for (int k = 0; k < len; k++) begin
      @(negedge CLK);
      drive(msg[k], 1'b1);
    end
    @(negedge CLK);
    drive(1'($urandom), 1'b0);
  endtask

  task automatic run_frame(input string tag, input int len, input logic [63:0] msg,
                           input bit use_exp, input logic [7:0] exp_a, input bit junk);
    logic [31:0] ea, eb, ec;
    ea = use_exp ? {24'd0, exp_a} : model_crc(8, 32'h44, 32'h00, len, msg);
    eb = model_crc(8, 32'h44, 32'hD8, len, msg);
    ec = model_crc(16, 32'h8408, 32'hFFFF, len, msg);
    send_bits(len, msg);
    for (int i = 0; i < 18; i++) begin
      @(negedge CLK);
      check_out(tag, i, ea, eb, ec);
      // Random activity is only legal while every instance is still shifting out.
      if (junk && i < 8) drive(1'($urandom), 1'($urandom));
      else drive(1'($urandom), 1'b0);
    end
  endtask

  initial begin
    logic [31:0] ea, eb, ec;
    logic [63:0] msg;

    vecs[0] = '{len: 8, msg: 64'h0,   exp_a: 8'h00};
    vecs[1] = '{len: 1, msg: 64'h1,   exp_a: 8'hC4};
    vecs[2] = '{len: 9, msg: 64'h189, exp_a: 8'h00};
    vecs[3] = '{len: 2, msg: 64'h3,   exp_a: 8'hA6};
    vecs[4] = '{len: 1, msg: 64'h0,   exp_a: 8'h00};

    RST = 1'b1;
    drive(1'b0, 1'b0);
    #1 RST = 1'b0;
    #2 check_idle("reset");
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    // Empty frame: active never rises.
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check_idle($sformatf("idle[%0d]", i));
    end

    foreach (vecs[v]) begin
      run_frame($sformatf("vec%0d", v), vecs[v].len, vecs[v].msg, 1'b1, vecs[v].exp_a, 1'b0);
    end

    // Every single-bit corruption of a zero-remainder frame must leave a nonzero remainder.
    for (int k = 0; k < 9; k++) begin
      run_frame($sformatf("flip%0d", k), 9, 64'h189 ^ (64'd1 << k), 1'b0, 8'h00, 1'b0);
    end

    // Reset during the fourth CRC bit, then a fresh frame must match a clean-reset run.
    msg = {$urandom, $urandom};
    ea  = model_crc(8, 32'h44, 32'h00, 8, msg);
    eb  = model_crc(8, 32'h44, 32'hD8, 8, msg);
    ec  = model_crc(16, 32'h8408, 32'hFFFF, 8, msg);
    send_bits(8, msg);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check_out("prerst", i, ea, eb, ec);
    end
    #2 RST = 1'b0;
    #1 check_idle("midrst");
    @(negedge CLK);
    check_idle("inrst");
    RST = 1'b1;
    @(negedge CLK);
    check_idle("postrst");
    run_frame("afterrst", 8, {$urandom, $urandom}, 1'b0, 8'h00, 1'b0);

    for (int r = 0; r < 20; r++) begin
      run_frame($sformatf("rnd%0d", r), int'($urandom_range(1, 40)), {$urandom, $urandom},
                1'b0, 8'h00, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
